vram_fill_ctrl: RTL and testbench

- Write-side controller for the 160x100 RGB332 framebuffer.
- Shares the framebuffer's single write port between two requesters: direct CPU pixel writes and a rectangle-fill engine (clear screen, solid boxes).
- Sits between the CPU/command logic and the video controller's write interface (write strobe, 14-bit address, 8-bit data).
- CPU writes always win; the fill engine stalls for them.

---
 rtl/vram_fill_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vram_fill_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: owns the single framebuffer write port and shares it between
// direct CPU pixel writes (always first) and a clipped rectangle-fill engine.
module vram_fill_ctrl #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 100,
    parameter int AW     = 14
) (
    input  logic          cpu_clk,
    input  logic          reset_n,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic [7:0]    cmd_w,
    input  logic [7:0]    cmd_h,
    input  logic [7:0]    cmd_color,
    input  logic          cmd_abort,
    output logic          vram_wr,
    output logic [AW-1:0] vram_addr,
    output logic [7:0]    vram_data,
    output logic          busy,
    output logic          done
);
    localparam logic [8:0]    WIDTH9   = 9'(WIDTH);
    localparam logic [8:0]    HEIGHT9  = 9'(HEIGHT);
    localparam logic [AW-1:0] WIDTH_AW = AW'(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_FILL, ST_FINISH} state_t;

    state_t        r_state;
    state_t        w_state_next;

    // Latched command
    logic [7:0]    r_x, r_y, r_w, r_h, r_color;
    // Clipped exclusive end coordinates and walking counters
    logic [8:0]    r_xe, r_ye;
    logic [7:0]    r_cx, r_cy;
    logic [AW-1:0] r_row_base;
    // Registered write port and status
    logic          r_vram_wr;
    logic [AW-1:0] r_vram_addr;
    logic [7:0]    r_vram_data;
    logic          r_busy;
    logic          r_done;

    logic          w_load_cmd;
    logic          w_setup;
    logic          w_fill_issue;
    logic [8:0]    w_x_end, w_y_end, w_xe, w_ye;
    logic          w_empty;
    logic [AW-1:0] w_row_base_calc;
    logic [AW-1:0] w_fill_addr;
    logic          w_row_end;
    logic          w_last;

    // 9-bit sums so x+w past 255 saturates at the edge instead of wrapping
    assign w_x_end = {1'b0, r_x} + {1'b0, r_w};
    assign w_y_end = {1'b0, r_y} + {1'b0, r_h};
    assign w_xe    = (w_x_end > WIDTH9)  ? WIDTH9  : w_x_end;
    assign w_ye    = (w_y_end > HEIGHT9) ? HEIGHT9 : w_y_end;
    assign w_empty = (r_w == 8'd0) || (r_h == 8'd0) ||
                     ({1'b0, r_x} >= WIDTH9) || ({1'b0, r_y} >= HEIGHT9);

    // y*160 = (y<<7)+(y<<5) avoids a multiplier; other widths fall back to a multiply
    generate
        if (WIDTH == 160) begin : g_row_shift
            assign w_row_base_calc = (AW'(r_y) << 7) + (AW'(r_y) << 5);
        end else begin : g_row_mul
            assign w_row_base_calc = AW'(r_y * WIDTH);
        end
    endgenerate

    assign w_fill_addr = r_row_base + AW'(r_cx);
    assign w_row_end   = (({1'b0, r_cx} + 9'd1) == r_xe);
    assign w_last      = w_row_end && (({1'b0, r_cy} + 9'd1) == r_ye);

    // State register
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and fill-issue decisions; a CPU write stalls the fill in place
    always_comb begin
        w_state_next = r_state;
        w_load_cmd   = 1'b0;
        w_setup      = 1'b0;
        w_fill_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_load_cmd   = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cmd_abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_setup      = 1'b1;
                    w_state_next = w_empty ? ST_FINISH : ST_FILL;
                end
            end
            ST_FILL: begin
                if (cmd_abort) begin
                    w_state_next = ST_IDLE;
                end else if (!cpu_wr) begin
                    w_fill_issue = 1'b1;
                    if (w_last) begin
                        w_state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, clip setup and row-major pixel walk
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= 8'd0;
            r_y        <= 8'd0;
            r_w        <= 8'd0;
            r_h        <= 8'd0;
            r_color    <= 8'd0;
            r_xe       <= 9'd0;
            r_ye       <= 9'd0;
            r_cx       <= 8'd0;
            r_cy       <= 8'd0;
            r_row_base <= '0;
        end else begin
            if (w_load_cmd) begin
                r_x     <= cmd_x;
                r_y     <= cmd_y;
                r_w     <= cmd_w;
                r_h     <= cmd_h;
                r_color <= cmd_color;
            end
            if (w_setup) begin
                r_xe       <= w_xe;
                r_ye       <= w_ye;
                r_cx       <= r_x;
                r_cy       <= r_y;
                r_row_base <= w_row_base_calc;
            end
            if (w_fill_issue && !w_last) begin
                if (w_row_end) begin
                    r_cx       <= r_x;
                    r_cy       <= r_cy + 8'd1;
                    r_row_base <= r_row_base + WIDTH_AW;
                end else begin
                    r_cx <= r_cx + 8'd1;
                end
            end
        end
    end

    // Registered write port: CPU write takes the slot, else the pending fill pixel
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vram_wr   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vram_wr <= cpu_wr | w_fill_issue;
            if (cpu_wr) begin
                r_vram_addr <= cpu_addr;
                r_vram_data <= cpu_data;
            end else if (w_fill_issue) begin
                r_vram_addr <= w_fill_addr;
                r_vram_data <= r_color;
            end
            r_busy <= (w_state_next == ST_SETUP) || (w_state_next == ST_FILL);
            r_done <= (r_state == ST_FINISH);
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign vram_wr   = r_vram_wr;
    assign vram_addr = r_vram_addr;
    assign vram_data = r_vram_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// tb_vram_fill_ctrl: directed and randomized stimulus for vram_fill_ctrl,
// compared every cycle against a pixel-list reference model.
module tb_vram_fill_ctrl;
    localparam int AW    = 14;
    localparam int FB_W  = 160;
    localparam int FB_H  = 100;

    logic          cpu_clk = 1'b0;
    logic          reset_n;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_x, cmd_y, cmd_w, cmd_h, cmd_color;
    logic          cmd_abort;
    logic          vram_wr;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_data;
    logic          busy;
    logic          done;

    vram_fill_ctrl #(.WIDTH(FB_W), .HEIGHT(FB_H), .AW(AW)) dut (
        .cpu_clk   (cpu_clk),
        .reset_n   (reset_n),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .cmd_abort (cmd_abort),
        .vram_wr   (vram_wr),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Reference model: a fill is a list of pixel addresses, drained one per free cycle
    typedef enum int {P_IDLE, P_SETUP, P_FILL, P_FINISH} phase_t;
    phase_t      m_ph;
    int          m_pix[$];
    logic [7:0]  m_color;
    int          m_npix;
    int          m_stolen;
    int          m_acc_cyc;
    int          lat_exp;
    int          lat_deadline;
    bit          lat_armed;

    logic        e_wr, e_busy, e_done, e_ready;
    logic [13:0] e_addr;
    logic [7:0]  e_data;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ph      = P_IDLE;
        m_pix.delete();
        e_wr      = 1'b0;
        e_addr    = 14'd0;
        e_data    = 8'd0;
        e_busy    = 1'b0;
        e_done    = 1'b0;
        e_ready   = 1'b1;
        lat_armed = 1'b0;
    endtask

    task automatic model_accept(input int x, input int y, input int w, input int h, input logic [7:0] col);
        int xe;
        int ye;
        xe = (x + w > FB_W) ? FB_W : x + w;
        ye = (y + h > FB_H) ? FB_H : y + h;
        m_pix.delete();
        for (int yy = y; yy < ye; yy++) begin
            for (int xx = x; xx < xe; xx++) begin
                m_pix.push_back(yy * FB_W + xx);
            end
        end
        m_color   = col;
        m_npix    = m_pix.size();
        m_stolen  = 0;
        m_acc_cyc = cyc;
        $display("cycle %0d: fill x=%0d y=%0d w=%0d h=%0d color=%02h -> %0d pixels",
                 cyc, x, y, w, h, col, m_npix);
    endtask

    // One clock: check what the last edge produced, then drive and predict the next edge
    task automatic cyc_step(input logic c_wr, input logic [13:0] c_addr, input logic [7:0] c_data,
                            input logic v, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h, input logic [7:0] col,
                            input logic ab);
        logic n_wr;
        @(negedge cpu_clk);
        check_eq("vram_wr", 32'(vram_wr), 32'(e_wr));
        if (e_wr) begin
            check_eq("vram_addr", 32'(vram_addr), 32'(e_addr));
            check_eq("vram_data", 32'(vram_data), 32'(e_data));
        end
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        if (lat_armed && done === 1'b1) begin
            check_eq("done_latency", 32'(cyc - m_acc_cyc), 32'(lat_exp));
            lat_armed = 1'b0;
        end else if (lat_armed && cyc > lat_deadline) begin
            lat_armed = 1'b0;
        end

        cpu_wr    = c_wr;
        cpu_addr  = c_addr;
        cpu_data  = c_data;
        cmd_valid = v;
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_color = col;
        cmd_abort = ab;

        n_wr   = 1'b0;
        e_done = 1'b0;
        if (c_wr) begin
            n_wr   = 1'b1;
            e_addr = c_addr;
            e_data = c_data;
        end
        case (m_ph)
            P_IDLE: begin
                if (v) begin
                    model_accept(int'(x), int'(y), int'(w), int'(h), col);
                    m_ph = P_SETUP;
                end
            end
            P_SETUP: begin
                if (ab) begin
                    m_ph = P_IDLE;
                    m_pix.delete();
                end else begin
                    m_ph = (m_pix.size() == 0) ? P_FINISH : P_FILL;
                end
            end
            P_FILL: begin
                if (ab) begin
                    m_ph = P_IDLE;
                    m_pix.delete();
                end else if (c_wr) begin
                    m_stolen++;
                end else begin
                    n_wr   = 1'b1;
                    e_addr = 14'(m_pix.pop_front());
                    e_data = m_color;
                    if (m_pix.size() == 0) m_ph = P_FINISH;
                end
            end
            default: begin
                m_ph         = P_IDLE;
                e_done       = 1'b1;
                lat_armed    = 1'b1;
                lat_exp      = m_npix + 3 + m_stolen;
                lat_deadline = cyc + 3;
            end
        endcase
        e_wr    = n_wr;
        e_busy  = (m_ph == P_SETUP) || (m_ph == P_FILL);
        e_ready = (m_ph == P_IDLE);
        cyc++;
    endtask

    task automatic idle_step();
        cyc_step(1'b0, 14'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic cpu_step(input logic [13:0] a, input logic [7:0] d);
        cyc_step(1'b1, a, d, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic abort_step();
        cyc_step(1'b0, 14'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    endtask

    task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                            input logic [7:0] h, input logic [7:0] col);
        cyc_step(1'b0, 14'd0, 8'd0, 1'b1, x, y, w, h, col, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_ph != P_IDLE && guard < 20000) begin
            idle_step();
            guard++;
        end
        check_eq("drain_bound", 32'(guard < 20000), 32'd1);
        repeat (3) idle_step();
    endtask

    task automatic async_reset_check();
        @(negedge cpu_clk);
        check_eq("busy_before_reset", 32'(busy), 32'(e_busy));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_vram_wr", 32'(vram_wr), 32'd0);
        check_eq("rst_vram_addr", 32'(vram_addr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        cpu_wr    = 1'b0;
        cmd_valid = 1'b0;
        cmd_abort = 1'b0;
        repeat (2) @(negedge cpu_clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_data  = 8'd0;
        cmd_valid = 1'b0;
        cmd_x     = 8'd0;
        cmd_y     = 8'd0;
        cmd_w     = 8'd0;
        cmd_h     = 8'd0;
        cmd_color = 8'd0;
        cmd_abort = 1'b0;
        repeat (2) @(negedge cpu_clk);
        check_eq("reset_vram_wr", 32'(vram_wr), 32'd0);
        check_eq("reset_vram_addr", 32'(vram_addr), 32'd0);
        check_eq("reset_vram_data", 32'(vram_data), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        model_reset();
        idle_step();

        // Small box, clipped corner, wide clip past 8-bit sum, degenerate commands
        send_cmd(8'd0, 8'd0, 8'd2, 8'd2, 8'hE0);
        drain();
        send_cmd(8'd158, 8'd99, 8'd5, 8'd3, 8'h1C);
        drain();
        send_cmd(8'd150, 8'd98, 8'd255, 8'd255, 8'h55);
        drain();
        send_cmd(8'd160, 8'd0, 8'd4, 8'd4, 8'h12);
        drain();
        send_cmd(8'd0, 8'd0, 8'd0, 8'd5, 8'h34);
        drain();
        send_cmd(8'd0, 8'd100, 8'd3, 8'd3, 8'h56);
        drain();

        // CPU write lands on the cycle the fill would issue address 1
        send_cmd(8'd0, 8'd0, 8'd4, 8'd1, 8'hFF);
        idle_step();
        idle_step();
        cpu_step(14'd9000, 8'h03);
        drain();

        // Full-screen fill aborted after 50 pixels, then a normal command
        send_cmd(8'd0, 8'd0, 8'd160, 8'd100, 8'hAA);
        repeat (51) idle_step();
        abort_step();
        idle_step();
        check_eq("abort_no_done", 32'(done), 32'd0);
        send_cmd(8'd3, 8'd4, 8'd5, 8'd2, 8'h77);
        drain();

        // Abort in SETUP together with a CPU write
        send_cmd(8'd10, 8'd10, 8'd3, 8'd3, 8'h11);
        cyc_step(1'b1, 14'd1234, 8'h9C, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        drain();

        // Asynchronous reset in the middle of a fill
        send_cmd(8'd0, 8'd0, 8'd160, 8'd100, 8'h3C);
        repeat (20) idle_step();
        async_reset_check();
        repeat (4) idle_step();
        send_cmd(8'd20, 8'd30, 8'd4, 8'd3, 8'hC3);
        drain();

        // Randomized traffic: CPU writes, commands (ignored while busy), rare aborts
        for (int i = 0; i < 4000; i++) begin
            cyc_step(1'($urandom_range(0, 4) == 0),
                     14'($urandom_range(0, 16383)),
                     8'($urandom),
                     1'($urandom_range(0, 7) == 0),
                     8'($urandom_range(0, 175)),
                     8'($urandom_range(0, 110)),
                     8'($urandom_range(0, 20)),
                     8'($urandom_range(0, 12)),
                     8'($urandom),
                     1'($urandom_range(0, 79) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
